// File: rtl/cache_arbiter.sv
// ============================================================================
//  Module      : cache_arbiter
//  Description : Round-robin arbiter that shares one memory port between the
//                I-cache and the D-cache. It latches the address at grant.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    // I-cache side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    // D-cache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    // memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_t;

    state_t              r_state_q,     w_state_d;
    logic                r_last_d_q,    w_last_d_d;
    logic                r_op_wr_q,     w_op_wr_d;
    logic                r_mem_read_q,  w_mem_read_d;
    logic                r_mem_write_q, w_mem_write_d;
    logic [ADDR_W-1:0]   r_mem_addr_q,  w_mem_addr_d;
    logic [LINE_W-1:0]   r_mem_wdata_q, w_mem_wdata_d;

    logic                w_d_req;

    assign w_d_req = d_read | d_write;

    always_comb begin
        w_state_d     = r_state_q;
        w_last_d_d    = r_last_d_q;
        w_op_wr_d     = r_op_wr_q;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_wdata_d = r_mem_wdata_q;

        case (r_state_q)
            ST_IDLE: begin
                // On a tie the side that was not granted last wins.
                if (i_read && (!w_d_req || r_last_d_q)) begin
                    w_state_d    = ST_SERVE_I;
                    w_mem_addr_d = i_addr;
                    w_op_wr_d    = 1'b0;
                    w_last_d_d   = 1'b0;
                end else if (w_d_req && (!i_read || !r_last_d_q)) begin
                    w_state_d     = ST_SERVE_D;
                    w_mem_addr_d  = d_addr;
                    w_mem_wdata_d = d_wdata;
                    w_op_wr_d     = d_write;
                    w_last_d_d    = 1'b1;
                end
            end
            ST_SERVE_I, ST_SERVE_D: begin
                if (mem_resp) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Strobes are registered from the next state so they line up with it.
        w_mem_read_d  = (w_state_d == ST_SERVE_I) ||
                        ((w_state_d == ST_SERVE_D) && !w_op_wr_d);
        w_mem_write_d = (w_state_d == ST_SERVE_D) && w_op_wr_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q     <= ST_IDLE;
            r_last_d_q    <= 1'b1;
            r_op_wr_q     <= 1'b0;
            r_mem_read_q  <= 1'b0;
            r_mem_write_q <= 1'b0;
            r_mem_addr_q  <= '0;
            r_mem_wdata_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_last_d_q    <= w_last_d_d;
            r_op_wr_q     <= w_op_wr_d;
            r_mem_read_q  <= w_mem_read_d;
            r_mem_write_q <= w_mem_write_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_mem_wdata_q <= w_mem_wdata_d;
        end
    end

    assign mem_read  = r_mem_read_q;
    assign mem_write = r_mem_write_q;
    assign mem_addr  = r_mem_addr_q;
    assign mem_wdata = r_mem_wdata_q;

    assign i_resp  = (r_state_q == ST_SERVE_I) && mem_resp;
    assign d_resp  = (r_state_q == ST_SERVE_D) && mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ============================================================================
//  Module      : tb_cache_arbiter
//  Description : Self-checking bench for cache_arbiter: directed scenarios
//                plus randomized traffic against a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, mem_resp = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0, d_addr = '0;
    logic [LINE_W-1:0] d_wdata = '0, mem_rdata = '0;
    logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
    logic              i_resp, d_resp, mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;

    int n_checks = 0;
    int n_fail   = 0;

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        n_checks++; if (mem_read  !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got %0b exp 0", mem_read); end
        n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write got %0b exp 0", mem_write); end
        n_checks++; if (mem_addr  !== '0)   begin n_fail++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        n_checks++; if (mem_wdata !== '0)   begin n_fail++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
        n_checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp got i=%0b d=%0b exp 0/0", i_resp, d_resp); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_i_read();
        logic [LINE_W-1:0] rd;
        @(negedge clk);
        i_read = 1'b1; i_addr = 32'h0000_1000;
        #1;
        n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL iread_idle_strobe got %0b exp 0", mem_read); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h1000)
                begin n_fail++; $display("FAIL iread_serve got rd=%0b wr=%0b addr=%h exp 1/0/1000", mem_read, mem_write, mem_addr); end
            n_checks++; if (i_resp !== 1'b0) begin n_fail++; $display("FAIL iread_early_resp got %0b exp 0", i_resp); end
        end
        @(negedge clk);
        rd = rand_line(); mem_rdata = rd; mem_resp = 1'b1;
        #1;
        n_checks++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin n_fail++; $display("FAIL iread_resp got i=%0b d=%0b exp 1/0", i_resp, d_resp); end
        n_checks++; if (i_rdata !== rd) begin n_fail++; $display("FAIL iread_rdata got %h exp %h", i_rdata, rd); end
        @(negedge clk);
        i_read = 1'b0; mem_resp = 1'b0;
        #1;
        n_checks++; if (i_resp !== 1'b0 || mem_read !== 1'b0) begin n_fail++; $display("FAIL iread_done got resp=%0b rd=%0b exp 0/0", i_resp, mem_read); end
    endtask

    task automatic test_d_write();
        logic [LINE_W-1:0] wd;
        wd = {(LINE_W/8){8'hA5}};
        @(negedge clk);
        d_write = 1'b1; d_addr = 32'h0000_2000; d_wdata = wd;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h2000 || mem_wdata !== wd)
                begin n_fail++; $display("FAIL dwrite_serve got wr=%0b rd=%0b addr=%h exp 1/0/2000", mem_write, mem_read, mem_addr); end
            d_wdata = rand_line();
        end
        @(negedge clk);
        mem_resp = 1'b1;
        #1;
        n_checks++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin n_fail++; $display("FAIL dwrite_resp got d=%0b i=%0b exp 1/0", d_resp, i_resp); end
        @(negedge clk);
        d_write = 1'b0; mem_resp = 1'b0;
        #1;
        n_checks++; if (d_resp !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL dwrite_done got resp=%0b wr=%0b exp 0/0", d_resp, mem_write); end
    endtask

    task automatic test_back_to_back();
        bit is_i;
        do_reset();
        i_read = 1'b1; d_read = 1'b1; i_addr = 32'h4000; d_addr = 32'h5000;
        for (int g = 0; g < 4; g++) begin
            is_i = (g % 2 == 0);
            @(negedge clk);
            mem_resp = 1'b1;
            #1;
            n_checks++; if (mem_read !== 1'b1 || mem_addr !== (is_i ? 32'h4000 : 32'h5000))
                begin n_fail++; $display("FAIL b2b_grant%0d got rd=%0b addr=%h exp I=%0b", g, mem_read, mem_addr, is_i); end
            n_checks++; if (i_resp !== is_i || d_resp !== !is_i)
                begin n_fail++; $display("FAIL b2b_resp%0d got i=%0b d=%0b exp I=%0b", g, i_resp, d_resp, is_i); end
            @(negedge clk);
            mem_resp = 1'b0;
            #1;
            n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0)
                begin n_fail++; $display("FAIL b2b_gap%0d got rd=%0b wr=%0b exp 0/0", g, mem_read, mem_write); end
        end
        i_read = 1'b0; d_read = 1'b0;
    endtask

    task automatic test_mid_change();
        @(negedge clk);
        i_read = 1'b1; i_addr = 32'h1000;
        @(negedge clk);
        i_read = 1'b0; i_addr = 32'h3000;
        #1;
        n_checks++; if (mem_addr !== 32'h1000 || mem_read !== 1'b1) begin n_fail++; $display("FAIL mid_addr got %h rd=%0b exp 1000/1", mem_addr, mem_read); end
        @(negedge clk);
        mem_resp = 1'b1;
        #1;
        n_checks++; if (i_resp !== 1'b1 || mem_addr !== 32'h1000) begin n_fail++; $display("FAIL mid_resp got %0b addr=%h exp 1/1000", i_resp, mem_addr); end
        @(negedge clk);
        mem_resp = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL mid_no_regrant got %0b exp 0", mem_read); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        d_read = 1'b1; d_addr = 32'h6000;
        @(negedge clk); #1;
        n_checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h6000) begin n_fail++; $display("FAIL areset_pre got rd=%0b addr=%h exp 1/6000", mem_read, mem_addr); end
        mem_resp = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== '0 || d_resp !== 1'b0)
            begin n_fail++; $display("FAIL areset_drop got rd=%0b wr=%0b addr=%h dresp=%0b exp 0", mem_read, mem_write, mem_addr, d_resp); end
        @(negedge clk);
        rst = 1'b1; mem_resp = 1'b0; d_read = 1'b0; i_read = 1'b1; i_addr = 32'h7000;
        #1;
        n_checks++; if (mem_read !== 1'b0 || d_resp !== 1'b0) begin n_fail++; $display("FAIL areset_idle got rd=%0b dresp=%0b exp 0/0", mem_read, d_resp); end
        @(negedge clk); #1;
        n_checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h7000) begin n_fail++; $display("FAIL areset_igrant got rd=%0b addr=%h exp 1/7000", mem_read, mem_addr); end
        mem_resp = 1'b1;
        #1;
        n_checks++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin n_fail++; $display("FAIL areset_iresp got i=%0b d=%0b exp 1/0", i_resp, d_resp); end
        @(negedge clk);
        i_read = 1'b0; mem_resp = 1'b0;
    endtask

    task automatic test_stray_resp();
        @(negedge clk);
        mem_resp = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0)
                begin n_fail++; $display("FAIL stray_resp got i=%0b d=%0b rd=%0b wr=%0b exp 0", i_resp, d_resp, mem_read, mem_write); end
            @(negedge clk);
        end
        mem_resp = 1'b0;
    endtask

    // Transaction-level model: who owns memory, which side wins the next tie,
    // and what was captured at the grant.
    task automatic test_random();
        int                owner;     // 0 none, 1 I, 2 D
        bit                i_first;
        bit                i_done, d_done;
        bit                e_rd, e_wr, e_ir, e_dr;
        logic [ADDR_W-1:0] ea;
        logic [LINE_W-1:0] ew;
        bit                ewr;
        int                op;
        do_reset();
        owner = 0; i_first = 1'b1; ea = '0; ew = '0; ewr = 1'b0;
        i_done = 1'b0; d_done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (i_done) i_read = 1'b0;
            else if (!i_read) begin
                if ($urandom_range(0, 2) == 0) begin i_read = 1'b1; i_addr = $urandom & 32'hFFFF_FFE0; end
            end else begin
                if ($urandom_range(0, 39) == 0) i_read = 1'b0;
                if ($urandom_range(0, 7) == 0)  i_addr = $urandom;
            end
            if (d_done) begin d_read = 1'b0; d_write = 1'b0; end
            else if (!(d_read || d_write)) begin
                if ($urandom_range(0, 2) == 0) begin
                    op = $urandom_range(0, 2);
                    d_read = (op != 1); d_write = (op != 0);
                    d_addr = $urandom & 32'hFFFF_FFE0; d_wdata = rand_line();
                end
            end else begin
                if ($urandom_range(0, 39) == 0) begin d_read = 1'b0; d_write = 1'b0; end
                if ($urandom_range(0, 7) == 0)  begin d_addr = $urandom; d_wdata = rand_line(); end
            end
            mem_resp  = ($urandom_range(0, 2) == 0);
            mem_rdata = rand_line();
            #1;
            e_ir = (owner == 1) && mem_resp;
            e_dr = (owner == 2) && mem_resp;
            e_rd = (owner == 1) || (owner == 2 && !ewr);
            e_wr = (owner == 2) && ewr;
            n_checks++; if (i_resp !== e_ir || d_resp !== e_dr)
                begin n_fail++; $display("FAIL rand_resp c=%0d got i=%0b d=%0b exp %0b/%0b", c, i_resp, d_resp, e_ir, e_dr); end
            n_checks++; if (mem_read !== e_rd || mem_write !== e_wr)
                begin n_fail++; $display("FAIL rand_strobe c=%0d got rd=%0b wr=%0b exp %0b/%0b", c, mem_read, mem_write, e_rd, e_wr); end
            if (owner != 0) begin
                n_checks++; if (mem_addr !== ea) begin n_fail++; $display("FAIL rand_addr c=%0d got %h exp %h", c, mem_addr, ea); end
            end
            if (owner == 2 && ewr) begin
                n_checks++; if (mem_wdata !== ew) begin n_fail++; $display("FAIL rand_wdata c=%0d got %h exp %h", c, mem_wdata, ew); end
            end
            if (e_ir) begin
                n_checks++; if (i_rdata !== mem_rdata) begin n_fail++; $display("FAIL rand_irdata c=%0d got %h exp %h", c, i_rdata, mem_rdata); end
            end
            if (e_dr) begin
                n_checks++; if (d_rdata !== mem_rdata) begin n_fail++; $display("FAIL rand_drdata c=%0d got %h exp %h", c, d_rdata, mem_rdata); end
            end
            i_done = e_ir;
            d_done = e_dr;
            if (owner != 0) begin
                if (mem_resp) owner = 0;
            end else if (i_read && (!(d_read || d_write) || i_first)) begin
                owner = 1; ea = i_addr; ewr = 1'b0; i_first = 1'b0;
            end else if (d_read || d_write) begin
                owner = 2; ea = d_addr; ew = d_wdata; ewr = d_write; i_first = 1'b1;
            end
        end
        @(negedge clk);
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_back_to_back();
        test_mid_change();
        test_async_reset();
        test_stray_resp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
